// File: rtl/matrixmult_sequencer.sv
// Sequencer feeding one 4x4 matrix by 4-vector transform through the external matrix multiplier.
// Optional WAIT_DONE watchdog is built only when MMSEQ_TIMEOUT_EN is defined.
module matrixmult_sequencer #(
  parameter int DATA_W  = 16,
  parameter int ACC_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [DATA_W-1:0] vec_0,
  input  logic [DATA_W-1:0] vec_1,
  input  logic [DATA_W-1:0] vec_2,
  input  logic [DATA_W-1:0] vec_3,
  output logic              mm_reset,
  output logic [31:0]       mm_in1,
  output logic [31:0]       mm_in2,
  output logic              mm_inputs_ready,
  input  logic              mm_done,
  input  logic [ACC_W-1:0]  mm_result0,
  input  logic [ACC_W-1:0]  mm_result1,
  input  logic [ACC_W-1:0]  mm_result2,
  input  logic [ACC_W-1:0]  mm_result3,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_0,
  output logic [ACC_W-1:0]  res_1,
  output logic [ACC_W-1:0]  res_2,
  output logic [ACC_W-1:0]  res_3,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CLEAR, ST_SETUP, ST_STROBE, ST_WAIT_DONE, ST_OUTPUT, ST_ABORT
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        idx_r;
  logic [DATA_W-1:0] m_r   [16];
  logic [DATA_W-1:0] v_r   [4];
  logic [ACC_W-1:0]  res_r [4];
  logic              accept_s;
  logic              timeout_s;

  assign accept_s = (state_r == ST_IDLE) && vec_valid;

  // State register, matrix/vector storage, pair index and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= 4'd0;
      for (int i = 0; i < 16; i++) m_r[i] <= {DATA_W{1'b0}};
      for (int i = 0; i < 4; i++) begin
        v_r[i]   <= {DATA_W{1'b0}};
        res_r[i] <= {ACC_W{1'b0}};
      end
    end else begin
      state_r <= state_s;
      if ((state_r == ST_IDLE) && cfg_we) begin
        m_r[cfg_addr] <= cfg_data;
      end
      if (accept_s) begin
        v_r[0] <= vec_0;
        v_r[1] <= vec_1;
        v_r[2] <= vec_2;
        v_r[3] <= vec_3;
        idx_r  <= 4'd0;
      end else if ((state_r == ST_STROBE) && (idx_r != 4'd15)) begin
        idx_r <= idx_r + 4'd1;
      end
      if ((state_r == ST_WAIT_DONE) && mm_done) begin
        res_r[0] <= mm_result0;
        res_r[1] <= mm_result1;
        res_r[2] <= mm_result2;
        res_r[3] <= mm_result3;
      end
    end
  end

`ifdef MMSEQ_TIMEOUT_EN
  logic [7:0] wait_cnt_r;
  logic       err_r;

  assign timeout_s = (state_r == ST_WAIT_DONE) && !mm_done &&
                     (wait_cnt_r == 8'(TIMEOUT - 1));
  assign err       = err_r;

  // Watchdog over WAIT_DONE; err stays set until reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= 8'd0;
      err_r      <= 1'b0;
    end else begin
      if (state_r != ST_WAIT_DONE) begin
        wait_cnt_r <= 8'd0;
      end else if (!mm_done) begin
        wait_cnt_r <= wait_cnt_r + 8'd1;
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end
`else
  // TIMEOUT only matters when the watchdog is built
  logic [7:0] unused_timeout_s;
  assign unused_timeout_s = 8'(TIMEOUT);
  assign timeout_s        = 1'b0;
  assign err              = 1'b0;
`endif

  // Next-state logic: one SETUP/STROBE pair per matrix element, row-major
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:      if (vec_valid) state_s = ST_CLEAR; else state_s = ST_IDLE;
      ST_CLEAR:     state_s = ST_SETUP;
      ST_SETUP:     state_s = ST_STROBE;
      ST_STROBE:    if (idx_r == 4'd15) state_s = ST_WAIT_DONE; else state_s = ST_SETUP;
      ST_WAIT_DONE: begin
        if (mm_done) begin
          state_s = ST_OUTPUT;
        end else if (timeout_s) begin
          state_s = ST_ABORT;
        end else begin
          state_s = ST_WAIT_DONE;
        end
      end
      ST_OUTPUT:    if (res_ready) state_s = ST_IDLE; else state_s = ST_OUTPUT;
      ST_ABORT:     state_s = ST_IDLE;
      default:      state_s = ST_IDLE;
    endcase
  end

  // Operand buses hold the current pair from SETUP through WAIT_DONE
  always_comb begin
    mm_in1          = 32'd0;
    mm_in2          = 32'd0;
    mm_inputs_ready = (state_r == ST_STROBE);
    if ((state_r == ST_SETUP) || (state_r == ST_STROBE) || (state_r == ST_WAIT_DONE)) begin
      mm_in1 = 32'(m_r[idx_r]);
      mm_in2 = 32'(v_r[idx_r[1:0]]);
    end else begin
      mm_in1 = 32'd0;
      mm_in2 = 32'd0;
    end
  end

  assign mm_reset  = reset || (state_r == ST_CLEAR) || (state_r == ST_ABORT);
  assign vec_ready = !reset && (state_r == ST_IDLE);
  assign res_valid = (state_r == ST_OUTPUT);
  assign busy      = (state_r != ST_IDLE);
  assign res_0     = res_r[0];
  assign res_1     = res_r[1];
  assign res_2     = res_r[2];
  assign res_3     = res_r[3];

endmodule

// File: tb/tb_matrixmult_sequencer.sv
// Directed bench for matrixmult_sequencer with a small behavioural matrix multiplier attached.
// Follows MMSEQ_TIMEOUT_EN for the watchdog scenario.
module tb_matrixmult_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        vec_valid, vec_ready;
  logic [15:0] vec_0, vec_1, vec_2, vec_3;
  logic        mm_reset;
  logic [31:0] mm_in1, mm_in2;
  logic        mm_inputs_ready, mm_done;
  logic [31:0] mm_result0, mm_result1, mm_result2, mm_result3;
  logic        res_valid, res_ready;
  logic [31:0] res_0, res_1, res_2, res_3;
  logic        busy, err;

  int errors = 0;
  int checks = 0;

  matrixmult_sequencer dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_0(vec_0), .vec_1(vec_1), .vec_2(vec_2), .vec_3(vec_3),
    .mm_reset(mm_reset), .mm_in1(mm_in1), .mm_in2(mm_in2),
    .mm_inputs_ready(mm_inputs_ready), .mm_done(mm_done),
    .mm_result0(mm_result0), .mm_result1(mm_result1),
    .mm_result2(mm_result2), .mm_result3(mm_result3),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_0(res_0), .res_1(res_1), .res_2(res_2), .res_3(res_3),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural multiplier: accumulates one row per four strobes, done after 16
  logic [31:0] acc [4];
  logic [4:0]  nstrobe;
  logic        model_done, block_done, force_done;

  always @(posedge clk) begin
    if (mm_reset) begin
      for (int i = 0; i < 4; i++) acc[i] <= 32'd0;
      nstrobe    <= 5'd0;
      model_done <= 1'b0;
    end else if (mm_inputs_ready) begin
      acc[nstrobe[3:2]] <= acc[nstrobe[3:2]] + mm_in1 * mm_in2;
      nstrobe <= nstrobe + 5'd1;
      if (nstrobe == 5'd15 && !block_done) model_done <= 1'b1;
    end
  end

  assign mm_done    = model_done | force_done;
  assign mm_result0 = acc[0];
  assign mm_result1 = acc[1];
  assign mm_result2 = acc[2];
  assign mm_result3 = acc[3];

  typedef struct {
    logic             we;
    logic [3:0]       addr;
    logic [15:0]      data;
    logic [3:0][15:0] v;
    logic [3:0][31:0] exp;
  } vec_t;

  vec_t        tbl [7];
  logic [31:0] s1_q[$];
  logic [31:0] s2_q[$];
  int          consec, nres, res_cyc;

  function automatic logic [3:0][15:0] vec4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [3:0][31:0] res4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic offer(input logic [3:0][15:0] v);
    int n;
    n = 0;
    vec_0 = v[0]; vec_1 = v[1]; vec_2 = v[2]; vec_3 = v[3];
    vec_valid = 1'b1;
    while (!vec_ready && n < 200) begin
      tick();
      n++;
    end
    chk("accept_ready", {31'd0, vec_ready}, 32'd1);
    tick();
    vec_valid = 1'b0;
  endtask

  // cyc counts cycles after the accept edge; returns the cycle res_valid was first seen
  task automatic wait_res(input int wr_cyc, input int done_cyc, output int cyc);
    logic prev;
    prev = 1'b0;
    cyc  = 1;
    s1_q.delete(); s2_q.delete();
    consec = 0; nres = 0; res_cyc = 0;
    while (!res_valid && cyc < 200) begin
      if (mm_inputs_ready) begin
        s1_q.push_back(mm_in1);
        s2_q.push_back(mm_in2);
        if (prev) consec++;
      end
      prev = mm_inputs_ready;
      if (mm_reset) begin
        nres++;
        res_cyc = cyc;
      end
      if (cyc == wr_cyc) cfg_we = 1'b1;
      if (cyc == done_cyc) force_done = 1'b1;
      tick();
      cfg_we = 1'b0;
      force_done = 1'b0;
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input logic [3:0][31:0] e);
    chk({tag, "_res0"}, res_0, e[0]);
    chk({tag, "_res1"}, res_1, e[1]);
    chk({tag, "_res2"}, res_2, e[2]);
    chk({tag, "_res3"}, res_3, e[3]);
  endtask

  task automatic handshake(input string tag);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, res_valid}, 32'd0);
    chk({tag, "_idle_ready"}, {31'd0, vec_ready}, 32'd1);
  endtask

  task automatic load_matrix();
    logic [15:0] mat [16];
    mat = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd3,
            16'd1, 16'd2, 16'd3, 16'd2, 16'd4, 16'd5, 16'd3, 16'd5};
    for (int i = 0; i < 16; i++) cfg_write(4'(i), mat[i]);
  endtask

  initial begin
    int cyc, bad, pulses, abort_cyc;
    logic seen_valid;

    tbl[0] = '{1'b0, 4'd0,  16'h0000, vec4(16'd2, 16'd5, 16'd3, 16'd1),
               res4(32'd16, 32'd64, 32'd23, 32'd47)};
    tbl[1] = '{1'b0, 4'd0,  16'h0000, vec4(16'd0, 16'd1, 16'd0, 16'd0),
               res4(32'd1, 32'd6, 32'd2, 32'd5)};
    tbl[2] = '{1'b0, 4'd0,  16'h0000, vec4(16'd0, 16'd0, 16'd0, 16'd1),
               res4(32'd3, 32'd3, 32'd2, 32'd5)};
    tbl[3] = '{1'b1, 4'd0,  16'hFFFF, vec4(16'hFFFF, 16'd0, 16'd0, 16'd0),
               res4(32'hFFFE0001, 32'h0004FFFB, 32'h0000FFFF, 32'h0003FFFC)};
    tbl[4] = '{1'b1, 4'd0,  16'h0001, vec4(16'd1, 16'd0, 16'd0, 16'd0),
               res4(32'd1, 32'd5, 32'd1, 32'd4)};
    tbl[5] = '{1'b1, 4'd15, 16'hFFFF, vec4(16'd0, 16'd0, 16'd0, 16'hFFFF),
               res4(32'h0002FFFD, 32'h0002FFFD, 32'h0001FFFE, 32'hFFFE0001)};
    tbl[6] = '{1'b1, 4'd15, 16'h0005, vec4(16'd0, 16'd0, 16'd1, 16'd0),
               res4(32'd2, 32'd7, 32'd3, 32'd3)};

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_data = 16'd0;
    vec_valid = 1'b0; vec_0 = 16'd0; vec_1 = 16'd0; vec_2 = 16'd0; vec_3 = 16'd0;
    res_ready = 1'b0; block_done = 1'b0; force_done = 1'b0;
    tick(); tick();
    chk("rst_vec_ready", {31'd0, vec_ready}, 32'd0);
    chk("rst_mm_reset",  {31'd0, mm_reset}, 32'd1);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err",       {31'd0, err}, 32'd0);
    chk("rst_strobe",    {31'd0, mm_inputs_ready}, 32'd0);
    chk("rst_res0",      res_0, 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_vec_ready", {31'd0, vec_ready}, 32'd1);
    chk("post_rst_mm_reset",  {31'd0, mm_reset}, 32'd0);
    load_matrix();

    // Table: optional IDLE config write, then one full transform
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].we) cfg_write(tbl[i].addr, tbl[i].data);
      offer(tbl[i].v);
      wait_res(0, (i == 1) ? 10 : 0, cyc);
      chk($sformatf("t%0d_latency", i), 32'(cyc), 32'd35);
      check_res($sformatf("t%0d", i), tbl[i].exp);
      if (i == 0) begin
        chk("strobe_count", 32'(s1_q.size()), 32'd16);
        if (s1_q.size() >= 5) begin
          chk("pair0", {s1_q[0][15:0], s2_q[0][15:0]}, {16'd1, 16'd2});
          chk("pair1", {s1_q[1][15:0], s2_q[1][15:0]}, {16'd1, 16'd5});
          chk("pair2", {s1_q[2][15:0], s2_q[2][15:0]}, {16'd2, 16'd3});
          chk("pair3", {s1_q[3][15:0], s2_q[3][15:0]}, {16'd3, 16'd1});
          chk("pair4", {s1_q[4][15:0], s2_q[4][15:0]}, {16'd5, 16'd2});
        end
        chk("no_back_to_back", 32'(consec), 32'd0);
        chk("mm_reset_pulses", 32'(nres), 32'd1);
        chk("mm_reset_cycle",  32'(res_cyc), 32'd1);
      end
      handshake($sformatf("t%0d", i));
    end

    // Backpressure in OUTPUT with a second vector pending
    offer(vec4(16'd2, 16'd5, 16'd3, 16'd1));
    wait_res(0, 0, cyc);
    vec_0 = 16'd1; vec_1 = 16'd0; vec_2 = 16'd0; vec_3 = 16'd0;
    vec_valid = 1'b1;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (!res_valid || vec_ready || !busy || res_0 !== 32'd16 || res_1 !== 32'd64 ||
          res_2 !== 32'd23 || res_3 !== 32'd47) bad++;
    end
    chk("output_hold", 32'(bad), 32'd0);
    handshake("bp");
    offer(vec4(16'd1, 16'd0, 16'd0, 16'd0));
    wait_res(0, 0, cyc);
    chk("bp_next_latency", 32'(cyc), 32'd35);
    check_res("bp_next", res4(32'd1, 32'd5, 32'd1, 32'd4));
    handshake("bp_next");

    // Config write while strobing is dropped; in IDLE or at accept it lands
    cfg_addr = 4'd5; cfg_data = 16'd9;
    offer(vec4(16'd0, 16'd1, 16'd0, 16'd0));
    wait_res(3, 0, cyc);
    chk("busy_write_res1", res_1, 32'd6);
    handshake("busy_write");
    cfg_write(4'd5, 16'd9);
    offer(vec4(16'd0, 16'd1, 16'd0, 16'd0));
    wait_res(0, 0, cyc);
    chk("idle_write_res1", res_1, 32'd9);
    handshake("idle_write");
    cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 16'd7;
    offer(vec4(16'd0, 16'd1, 16'd0, 16'd0));
    cfg_we = 1'b0;
    wait_res(0, 0, cyc);
    chk("accept_write_res1", res_1, 32'd7);
    handshake("accept_write");

    // Reset in the middle of a transform
    offer(vec4(16'd2, 16'd5, 16'd3, 16'd1));
    for (int k = 1; k < 20; k++) tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_vec_ready", {31'd0, vec_ready}, 32'd0);
    chk("mid_rst_mm_reset",  {31'd0, mm_reset}, 32'd1);
    chk("mid_rst_busy",      {31'd0, busy}, 32'd0);
    chk("mid_rst_strobe",    {31'd0, mm_inputs_ready}, 32'd0);
    chk("mid_rst_in1",       mm_in1, 32'd0);
    chk("mid_rst_in2",       mm_in2, 32'd0);
    chk("mid_rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("mid_rst_res1",      res_1, 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_rst_idle", {31'd0, vec_ready}, 32'd1);
    load_matrix();
    offer(vec4(16'd2, 16'd5, 16'd3, 16'd1));
    wait_res(0, 0, cyc);
    chk("after_rst_latency", 32'(cyc), 32'd35);
    check_res("after_rst", res4(32'd16, 32'd64, 32'd23, 32'd47));
    handshake("after_rst");

    // Multiplier never finishes
    block_done = 1'b1;
    offer(vec4(16'd2, 16'd5, 16'd3, 16'd1));
    cyc = 1; pulses = 0; abort_cyc = 0; seen_valid = 1'b0;
    while (busy && cyc < 150) begin
      if (mm_reset && cyc > 1) begin
        pulses++;
        abort_cyc = cyc;
      end
      if (res_valid) seen_valid = 1'b1;
      tick();
      cyc++;
    end
    chk("stall_no_valid", {31'd0, seen_valid}, 32'd0);
`ifdef MMSEQ_TIMEOUT_EN
    chk("timeout_idle_cycle", 32'(cyc), 32'd99);
    chk("timeout_abort_cycle", 32'(abort_cyc), 32'd98);
    chk("timeout_pulses", 32'(pulses), 32'd1);
    chk("timeout_err", {31'd0, err}, 32'd1);
    tick();
    chk("timeout_err_sticky", {31'd0, err}, 32'd1);
`else
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_pulses", 32'(pulses), 32'd0);
    chk("stall_err", {31'd0, err}, 32'd0);
`endif
    block_done = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("final_err_clear", {31'd0, err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
